// File: rtl/motion_frame_analyzer_if.sv
// Pixel-stream input and per-frame summary record shared between the
// motion detection stage, the frame analyzer and the host/overlay logic.
interface motion_frame_analyzer_if #(
  parameter int XW = 10,
  parameter int YW = 9,
  parameter int CW = 19
);
  logic          pix_valid;
  logic          sof;
  logic          motion_bit;
  logic [CW-1:0] min_pixels;
  logic          res_ready;
  logic          res_valid;
  logic [CW-1:0] res_count;
  logic [XW-1:0] res_x_min;
  logic [XW-1:0] res_x_max;
  logic [YW-1:0] res_y_min;
  logic [YW-1:0] res_y_max;
  logic          res_empty;
  logic          res_alarm;
  logic          overrun;
  logic          frame_err;
  logic          busy;

  modport master (
    output pix_valid, sof, motion_bit, min_pixels, res_ready,
    input  res_valid, res_count, res_x_min, res_x_max, res_y_min, res_y_max,
    input  res_empty, res_alarm, overrun, frame_err, busy
  );

  modport slave (
    input  pix_valid, sof, motion_bit, min_pixels, res_ready,
    output res_valid, res_count, res_x_min, res_x_max, res_y_min, res_y_max,
    output res_empty, res_alarm, overrun, frame_err, busy
  );
endinterface

// File: rtl/motion_frame_analyzer.sv
// Accumulates motion pixel count and bounding box over a raster frame and
// publishes one summary record per completed frame on a valid/ready port.
module motion_frame_analyzer #(
  parameter int IMG_W = 640,
  parameter int IMG_H = 480,
  parameter int XW    = 10,
  parameter int YW    = 9,
  parameter int CW    = 19
) (
  input  logic                    clk,
  input  logic                    rst,
  motion_frame_analyzer_if.slave  bus
);

  typedef enum logic [0:0] {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
  localparam logic [XW-1:0] X_ONE  = XW'(1);
  localparam logic [YW-1:0] Y_ONE  = YW'(1);
  localparam logic [CW-1:0] C_ONE  = CW'(1);

  state_t        state_r;
  logic          busy_r, frame_err_r, overrun_r;
  logic [XW-1:0] x_r, x_min_r, x_max_r;
  logic [YW-1:0] y_r, y_min_r, y_max_r;
  logic [CW-1:0] cnt_r, thr_r;

  logic          res_valid_r, res_empty_r, res_alarm_r;
  logic [CW-1:0] res_count_r;
  logic [XW-1:0] res_x_min_r, res_x_max_r;
  logic [YW-1:0] res_y_min_r, res_y_max_r;

  logic          start_s, acc_s, last_s, adv_s, load_s, empty_s, alarm_s;
  logic [XW-1:0] px_s, nx_s, base_x_min_s, base_x_max_s, new_x_min_s, new_x_max_s;
  logic [YW-1:0] py_s, ny_s, base_y_min_s, base_y_max_s, new_y_min_s, new_y_max_s;
  logic [CW-1:0] base_cnt_s, new_cnt_s;

  // Current pixel position and the frame statistics including that pixel
  always_comb begin
    start_s = bus.pix_valid & bus.sof;
    acc_s   = bus.pix_valid & ~bus.sof & (state_r == ACCUM);
    last_s  = acc_s & (x_r == X_LAST) & (y_r == Y_LAST);
    adv_s   = start_s | (acc_s & ~last_s);

    // A sof pixel always starts from an empty frame at (0,0), even mid-frame
    if (start_s) begin
      px_s         = {XW{1'b0}};
      py_s         = {YW{1'b0}};
      base_cnt_s   = {CW{1'b0}};
      base_x_min_s = {XW{1'b0}};
      base_x_max_s = {XW{1'b0}};
      base_y_min_s = {YW{1'b0}};
      base_y_max_s = {YW{1'b0}};
    end else begin
      px_s         = x_r;
      py_s         = y_r;
      base_cnt_s   = cnt_r;
      base_x_min_s = x_min_r;
      base_x_max_s = x_max_r;
      base_y_min_s = y_min_r;
      base_y_max_s = y_max_r;
    end

    if (bus.motion_bit) begin
      new_cnt_s = base_cnt_s + C_ONE;
      if (base_cnt_s == {CW{1'b0}}) begin
        new_x_min_s = px_s;
        new_x_max_s = px_s;
        new_y_min_s = py_s;
        new_y_max_s = py_s;
      end else begin
        new_x_min_s = (px_s < base_x_min_s) ? px_s : base_x_min_s;
        new_x_max_s = (px_s > base_x_max_s) ? px_s : base_x_max_s;
        new_y_min_s = (py_s < base_y_min_s) ? py_s : base_y_min_s;
        new_y_max_s = (py_s > base_y_max_s) ? py_s : base_y_max_s;
      end
    end else begin
      new_cnt_s   = base_cnt_s;
      new_x_min_s = base_x_min_s;
      new_x_max_s = base_x_max_s;
      new_y_min_s = base_y_min_s;
      new_y_max_s = base_y_max_s;
    end

    if (px_s == X_LAST) begin
      nx_s = {XW{1'b0}};
      ny_s = py_s + Y_ONE;
    end else begin
      nx_s = px_s + X_ONE;
      ny_s = py_s;
    end

    empty_s = (new_cnt_s == {CW{1'b0}});
    alarm_s = (new_cnt_s >= thr_r);
    load_s  = last_s & (~res_valid_r | bus.res_ready);
  end

  // Frame state machine, position counters and accumulators
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= IDLE;
      busy_r      <= 1'b0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
      x_r         <= {XW{1'b0}};
      y_r         <= {YW{1'b0}};
      cnt_r       <= {CW{1'b0}};
      thr_r       <= {CW{1'b0}};
      x_min_r     <= {XW{1'b0}};
      x_max_r     <= {XW{1'b0}};
      y_min_r     <= {YW{1'b0}};
      y_max_r     <= {YW{1'b0}};
    end else begin
      frame_err_r <= start_s & (state_r == ACCUM);
      overrun_r   <= last_s & res_valid_r & ~bus.res_ready;
      case (state_r)
        IDLE: begin
          if (start_s) begin
            state_r <= ACCUM;
            busy_r  <= 1'b1;
          end
        end
        ACCUM: begin
          if (last_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
          end
        end
        default: begin
          state_r <= IDLE;
          busy_r  <= 1'b0;
        end
      endcase
      if (start_s) begin
        thr_r <= bus.min_pixels;
      end
      if (adv_s) begin
        x_r     <= nx_s;
        y_r     <= ny_s;
        cnt_r   <= new_cnt_s;
        x_min_r <= new_x_min_s;
        x_max_r <= new_x_max_s;
        y_min_r <= new_y_min_s;
        y_max_r <= new_y_max_s;
      end else if (last_s) begin
        x_r     <= {XW{1'b0}};
        y_r     <= {YW{1'b0}};
        cnt_r   <= {CW{1'b0}};
        x_min_r <= {XW{1'b0}};
        x_max_r <= {XW{1'b0}};
        y_min_r <= {YW{1'b0}};
        y_max_r <= {YW{1'b0}};
      end
    end
  end

  // Output record: loads on frame completion unless an unaccepted record is held
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res_valid_r <= 1'b0;
      res_empty_r <= 1'b0;
      res_alarm_r <= 1'b0;
      res_count_r <= {CW{1'b0}};
      res_x_min_r <= {XW{1'b0}};
      res_x_max_r <= {XW{1'b0}};
      res_y_min_r <= {YW{1'b0}};
      res_y_max_r <= {YW{1'b0}};
    end else if (load_s) begin
      res_valid_r <= 1'b1;
      res_empty_r <= empty_s;
      res_alarm_r <= alarm_s;
      res_count_r <= new_cnt_s;
      res_x_min_r <= empty_s ? {XW{1'b0}} : new_x_min_s;
      res_x_max_r <= empty_s ? {XW{1'b0}} : new_x_max_s;
      res_y_min_r <= empty_s ? {YW{1'b0}} : new_y_min_s;
      res_y_max_r <= empty_s ? {YW{1'b0}} : new_y_max_s;
    end else if (res_valid_r & bus.res_ready) begin
      res_valid_r <= 1'b0;
    end
  end

  assign bus.res_valid = res_valid_r;
  assign bus.res_count = res_count_r;
  assign bus.res_x_min = res_x_min_r;
  assign bus.res_x_max = res_x_max_r;
  assign bus.res_y_min = res_y_min_r;
  assign bus.res_y_max = res_y_max_r;
  assign bus.res_empty = res_empty_r;
  assign bus.res_alarm = res_alarm_r;
  assign bus.overrun   = overrun_r;
  assign bus.frame_err = frame_err_r;
  assign bus.busy      = busy_r;

endmodule

// File: tb/tb_motion_frame_analyzer.sv
// Drives directed and random pixel streams into a 4x3 analyzer and compares
// every cycle against a frame-level reference model.
module tb_motion_frame_analyzer;
  localparam int W = 4, H = 3, XW = 2, YW = 2, CW = 4, NPIX = W * H;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  motion_frame_analyzer_if #(.XW(XW), .YW(YW), .CW(CW)) bus ();

  motion_frame_analyzer #(.IMG_W(W), .IMG_H(H), .XW(XW), .YW(YW), .CW(CW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int test_cnt = 0;
  int fail_cnt = 0;

  // Reference model: frame as a list of linear motion pixel indices
  bit m_busy;
  int m_pos, m_thr;
  int m_motion[$];
  bit e_valid, e_empty, e_alarm, e_ovr, e_ferr;
  int e_cnt, e_xmin, e_xmax, e_ymin, e_ymax;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    test_cnt++;
    if (act !== exp) begin
      fail_cnt++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_busy = 1'b0; m_pos = 0; m_thr = 0; m_motion.delete();
    e_valid = 1'b0; e_ovr = 1'b0; e_ferr = 1'b0;
  endtask

  task automatic publish();
    e_valid = 1'b1;
    e_cnt   = m_motion.size();
    e_empty = (e_cnt == 0);
    e_alarm = (e_cnt >= m_thr);
    e_xmin = 0; e_xmax = 0; e_ymin = 0; e_ymax = 0;
    if (e_cnt > 0) begin
      e_xmin = W; e_ymin = H; e_xmax = -1; e_ymax = -1;
      foreach (m_motion[i]) begin
        int x = m_motion[i] % W;
        int y = m_motion[i] / W;
        if (x < e_xmin) e_xmin = x;
        if (x > e_xmax) e_xmax = x;
        if (y < e_ymin) e_ymin = y;
        if (y > e_ymax) e_ymax = y;
      end
    end
  endtask

  task automatic model_step(input bit pv, input bit sof, input bit mb, input int thr, input bit rdy);
    bit done = 1'b0;
    bit acc  = e_valid && rdy;
    e_ovr = 1'b0; e_ferr = 1'b0;
    if (pv && sof) begin
      if (m_busy) e_ferr = 1'b1;
      m_busy = 1'b1; m_pos = 0; m_thr = thr; m_motion.delete();
    end
    if (pv && m_busy) begin
      if (mb) m_motion.push_back(m_pos);
      if (m_pos == NPIX - 1) begin
        done = 1'b1; m_busy = 1'b0;
      end else begin
        m_pos++;
      end
    end
    if (done) begin
      if (e_valid && !rdy) e_ovr = 1'b1;
      else publish();
    end else if (acc) begin
      e_valid = 1'b0;
    end
  endtask

  task automatic check_outputs();
    check_eq("res_valid", bus.res_valid, e_valid);
    check_eq("overrun", bus.overrun, e_ovr);
    check_eq("frame_err", bus.frame_err, e_ferr);
    check_eq("busy", bus.busy, m_busy);
    if (e_valid) begin
      check_eq("res_count", bus.res_count, e_cnt);
      check_eq("res_x_min", bus.res_x_min, e_xmin);
      check_eq("res_x_max", bus.res_x_max, e_xmax);
      check_eq("res_y_min", bus.res_y_min, e_ymin);
      check_eq("res_y_max", bus.res_y_max, e_ymax);
      check_eq("res_empty", bus.res_empty, e_empty);
      check_eq("res_alarm", bus.res_alarm, e_alarm);
    end
  endtask

  task automatic cycle(input bit pv, input bit sof, input bit mb, input int thr, input bit rdy);
    bus.pix_valid  = pv;
    bus.sof        = sof;
    bus.motion_bit = mb;
    bus.min_pixels = CW'(thr);
    bus.res_ready  = rdy;
    @(posedge clk);
    model_step(pv, sof, mb, thr, rdy);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0, 0, rdy);
  endtask

  task automatic run_frame(input bit [NPIX-1:0] mask, input int thr, input bit toggle,
                           input bit rdy, input bit rdy_last);
    for (int p = 0; p < NPIX; p++) begin
      if (toggle && p > 0) cycle(1'b0, 1'b0, 1'b1, thr, rdy);
      cycle(1'b1, p == 0, mask[p], thr, (p == NPIX - 1) ? rdy_last : rdy);
    end
  endtask

  initial begin
    bus.pix_valid = 1'b0; bus.sof = 1'b0; bus.motion_bit = 1'b0;
    bus.min_pixels = '0; bus.res_ready = 1'b0;
    model_reset();
    rst = 1'b0;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    check_eq("rst_res_valid", bus.res_valid, 0);
    check_eq("rst_busy", bus.busy, 0);
    check_eq("rst_res_count", bus.res_count, 0);
    check_eq("rst_pulses", {bus.overrun, bus.frame_err}, 0);
    rst = 1'b0;
    idle(1, 1'b0);

    // Single motion pixel at (2,1)
    run_frame(12'h040, 1, 1'b0, 1'b0, 1'b0);
    idle(1, 1'b1); idle(1, 1'b0);
    // Empty frames, threshold 0 then 5
    run_frame(12'h000, 0, 1'b0, 1'b0, 1'b0); idle(1, 1'b1);
    run_frame(12'h000, 5, 1'b0, 1'b0, 1'b0); idle(1, 1'b1);
    // Full motion with pix_valid toggling
    run_frame(12'hFFF, 12, 1'b1, 1'b0, 1'b0); idle(1, 1'b1);
    // Backpressure across two frames, then accept
    run_frame(12'h0A5, 3, 1'b0, 1'b0, 1'b0);
    run_frame(12'h300, 1, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0); idle(1, 1'b1); idle(1, 1'b0);
    // Acceptance on the same edge as the next completion
    run_frame(12'h00F, 2, 1'b0, 1'b0, 1'b0);
    run_frame(12'h800, 1, 1'b0, 1'b0, 1'b1);
    idle(1, 1'b1); idle(1, 1'b0);
    // sof at (1,1) mid-frame, then a full frame with motion at (0,0)
    for (int p = 0; p < 5; p++) cycle(1'b1, p == 0, 1'b1, 4, 1'b0);
    run_frame(12'h001, 1, 1'b0, 1'b1, 1'b1);
    idle(2, 1'b1);
    // Reset mid-frame with a record pending
    run_frame(12'h111, 1, 1'b0, 1'b0, 1'b0);
    for (int p = 0; p < 6; p++) cycle(1'b1, p == 0, 1'b1, 1, 1'b0);
    rst = 1'b1;
    #1;
    check_eq("midrst_res_valid", bus.res_valid, 0);
    check_eq("midrst_busy", bus.busy, 0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    idle(2, 1'b1);

    // Random traffic: gaps, restarts, backpressure, thresholds
    for (int i = 0; i < 1500; i++) begin
      bit pv  = ($urandom_range(0, 3) != 0);
      bit sof = m_busy ? ($urandom_range(0, 59) == 0) : ($urandom_range(0, 2) == 0);
      cycle(pv, sof, 1'($urandom_range(0, 1)), $urandom_range(0, 13),
            ($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
    $finish;
  end
endmodule
